// File: rtl/vga_pkg.sv
// Shared phase encoding, counter widths and 640x480@60 default timing for the
// VGA timing controller and its per-axis phase sequencer.
package vga_pkg;

  typedef enum logic [2:0] {PH_IDLE, PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned LEN_W = CNT_W + 1;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic        DEF_SYNC_POL = 1'b0;

  // Every phase must last at least one unit and a whole axis must fit the 10-bit counter.
  function automatic logic timing_ok(int unsigned a, int unsigned f, int unsigned s,
                                     int unsigned b);
    return (a >= 1) && (f >= 1) && (s >= 1) && (b >= 1) && ((a + f + s + b) <= 1024);
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// Generic ACT->FP->SYNC->BP phase sequencer with a per-phase position counter;
// used once per axis of the VGA timing controller.
module vga_axis_seq
  import vga_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             enable_i,
  input  logic [LEN_W-1:0] len_act_i,
  input  logic [LEN_W-1:0] len_fp_i,
  input  logic [LEN_W-1:0] len_sync_i,
  input  logic [LEN_W-1:0] len_bp_i,
  output phase_t           phase_o,
  output phase_t           phase_nxt_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] pos_o
);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cur_len;
  logic             last;

  always_comb begin
    cur_len = len_act_i;
    case (phase_q)
      PH_FP:   cur_len = len_fp_i;
      PH_SYNC: cur_len = len_sync_i;
      PH_BP:   cur_len = len_bp_i;
      default: cur_len = len_act_i;
    endcase
  end

  assign last   = ({1'b0, cnt_q} == (cur_len - LEN_W'(1)));
  // wrap_o is kept independent of enable_i so the caller may feed it back into enable_i.
  assign wrap_o = step_i && (phase_q == PH_BP) && last;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (phase_q == PH_IDLE) begin
      if (start_i) begin
        phase_d = PH_ACT;
        cnt_d   = '0;
      end
    end else if (step_i) begin
      if (last) begin
        cnt_d = '0;
        case (phase_q)
          PH_ACT:  phase_d = PH_FP;
          PH_FP:   phase_d = PH_SYNC;
          PH_SYNC: phase_d = PH_BP;
          PH_BP:   phase_d = enable_i ? PH_ACT : PH_IDLE;
          default: phase_d = PH_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_o     = phase_q;
  assign phase_nxt_o = phase_d;
  assign pos_o       = cnt_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: sync, active flag, coordinates and line/frame pulses
// from two phase sequencers, with start/stop aligned to frame boundaries.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = DEF_SYNC_POL
) (
  input  logic             pixelClk,
  input  logic             locked,
  input  logic             enable,
  output logic             running,
  output logic             hSync,
  output logic             vSync,
  output logic             active,
  output logic [CNT_W-1:0] xCor,
  output logic [CNT_W-1:0] yCor,
  output logic             lineStart,
  output logic             frameStart
);

  if (!timing_ok(H_ACTIVE, H_FP, H_SYNC, H_BP)) begin : g_bad_h
    $error("vga_timing_ctrl: horizontal phase lengths must be >=1 and total <=1024");
  end
  if (!timing_ok(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_bad_v
    $error("vga_timing_ctrl: vertical phase lengths must be >=1 and total <=1024");
  end

  phase_t           h_ph, h_nxt, v_ph, v_nxt;
  logic             h_wrap, v_wrap, start, h_cont;
  logic [CNT_W-1:0] h_pos, v_pos;

  assign start  = (h_ph == PH_IDLE) && enable;
  // H only falls back to IDLE on the line-end step that also finishes the frame.
  assign h_cont = enable || !v_wrap;

  vga_axis_seq u_h (
    .clk_i       (pixelClk),
    .rst_n_i     (locked),
    .start_i     (start),
    .step_i      (1'b1),
    .enable_i    (h_cont),
    .len_act_i   (LEN_W'(H_ACTIVE)),
    .len_fp_i    (LEN_W'(H_FP)),
    .len_sync_i  (LEN_W'(H_SYNC)),
    .len_bp_i    (LEN_W'(H_BP)),
    .phase_o     (h_ph),
    .phase_nxt_o (h_nxt),
    .wrap_o      (h_wrap),
    .pos_o       (h_pos)
  );

  vga_axis_seq u_v (
    .clk_i       (pixelClk),
    .rst_n_i     (locked),
    .start_i     (start),
    .step_i      (h_wrap),
    .enable_i    (enable),
    .len_act_i   (LEN_W'(V_ACTIVE)),
    .len_fp_i    (LEN_W'(V_FP)),
    .len_sync_i  (LEN_W'(V_SYNC)),
    .len_bp_i    (LEN_W'(V_BP)),
    .phase_o     (v_ph),
    .phase_nxt_o (v_nxt),
    .wrap_o      (v_wrap),
    .pos_o       (v_pos)
  );

  logic             running_q, running_d, active_q, active_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             line_q, line_d, frame_q, frame_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  // Outputs are decoded from the sequencers' next state so they register on the same edge.
  always_comb begin
    running_d = (h_nxt != PH_IDLE);
    active_d  = (h_nxt == PH_ACT) && (v_nxt == PH_ACT);
    hsync_d   = (h_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d   = (v_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    line_d    = (h_nxt == PH_ACT) && (h_ph != PH_ACT);
    frame_d   = line_d && (v_nxt == PH_ACT) && (v_ph != PH_ACT);
    x_d       = '0;
    if (active_d && !line_d) begin
      x_d = h_pos + CNT_W'(1);
    end
    y_d = '0;
    if ((v_nxt == PH_ACT) && (v_ph == PH_ACT)) begin
      y_d = h_wrap ? (v_pos + CNT_W'(1)) : v_pos;
    end
  end

  always_ff @(posedge pixelClk or negedge locked) begin
    if (!locked) begin
      running_q <= 1'b0;
      active_q  <= 1'b0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      running_q <= running_d;
      active_q  <= active_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign running    = running_q;
  assign active     = active_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign lineStart  = line_q;
  assign frameStart = frame_q;
  assign xCor       = x_q;
  assign yCor       = y_q;

endmodule
